// File: rtl/cotm32_pkg.sv
// rtl/cotm32_pkg.sv - shared core types: XLEN and branch-history counter state/transition.
package cotm32_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_state_t;

   // Saturating step toward the resolved direction.
   function automatic bht_state_t bht_next(input bht_state_t s, input logic take);
      bht_state_t n;
      n = s;
      if (take && (s != ST)) begin
         n = bht_state_t'(s + 2'd1);
      end else if (!take && (s != SNT)) begin
         n = bht_state_t'(s - 2'd1);
      end
      return n;
   endfunction

endpackage

// File: rtl/bht_ctr.sv
// rtl/bht_ctr.sv - one 2-bit saturating direction counter of the branch history table.
module bht_ctr
   import cotm32_pkg::*;
#(
   parameter bht_state_t INIT_STATE = WNT
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic       i_take,
   output bht_state_t o_state
);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_state <= INIT_STATE;
      end else if (i_en) begin
         o_state <= bht_next(o_state, i_take);
      end
   end

endmodule

// File: rtl/bht.sv
// rtl/bht.sv - branch history table: PC-indexed 2-bit predictor with write-first bypass,
// registered prediction, mispredict flag and branch/mispredict event counters.
module bht
   import cotm32_pkg::*;
#(
   parameter int         ENTRIES    = 64,
   parameter bht_state_t INIT_STATE = WNT,
   parameter int         CNT_W      = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_lookup_valid,
   input  logic [XLEN-1:0]  i_lookup_pc,
   input  logic             i_flush,
   output logic             o_pred_valid,
   output logic             o_pred_taken,
   input  logic             i_upd_valid,
   input  logic [XLEN-1:0]  i_upd_pc,
   input  logic             i_upd_take,
   input  logic             i_upd_pred,
   output logic             o_mispredict,
   output logic [CNT_W-1:0] o_branch_count,
   output logic [CNT_W-1:0] o_mispredict_count
);

   localparam int IDX_W = $clog2(ENTRIES);

   logic [IDX_W-1:0] lk_idx;
   logic [IDX_W-1:0] upd_idx;
   bht_state_t       ctr_state [ENTRIES];
   bht_state_t       lk_raw;
   bht_state_t       lk_state;
   logic             lk_fire;
   logic             unused_pc_bits;

   // Untagged table: low two PC bits and everything above the index simply alias.
   assign lk_idx  = i_lookup_pc[IDX_W+1:2];
   assign upd_idx = i_upd_pc[IDX_W+1:2];
   assign unused_pc_bits = ^{i_lookup_pc[XLEN-1:IDX_W+2], i_lookup_pc[1:0],
                             i_upd_pc[XLEN-1:IDX_W+2], i_upd_pc[1:0]};

   for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
      bht_ctr #(
         .INIT_STATE(INIT_STATE)
      ) u_ctr (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_en    (i_upd_valid && (upd_idx == IDX_W'(g))),
         .i_take  (i_upd_take),
         .o_state (ctr_state[g])
      );
   end

   // Same-index update in this cycle: predict from the value being written.
   assign lk_raw   = ctr_state[lk_idx];
   assign lk_state = (i_upd_valid && (upd_idx == lk_idx)) ? bht_next(lk_raw, i_upd_take) : lk_raw;
   assign lk_fire  = i_lookup_valid && !i_flush;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_pred_valid <= 1'b0;
         o_pred_taken <= 1'b0;
      end else begin
         o_pred_valid <= lk_fire;
         if (lk_fire) begin
            o_pred_taken <= lk_state[1];
         end
      end
   end

   assign o_mispredict = i_upd_valid && (i_upd_take != i_upd_pred);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_branch_count     <= '0;
         o_mispredict_count <= '0;
      end else if (i_upd_valid) begin
         o_branch_count <= o_branch_count + CNT_W'(1);
         if (o_mispredict) begin
            o_mispredict_count <= o_mispredict_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bht.sv
// tb/tb_bht.sv - directed self-checking bench for bht (64 entries, plus a 4-bit-counter instance).
module tb_bht;
   import cotm32_pkg::*;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            lookup_valid;
   logic [XLEN-1:0] lookup_pc;
   logic            flush;
   logic            upd_valid;
   logic [XLEN-1:0] upd_pc;
   logic            upd_take;
   logic            upd_pred;

   logic            pred_valid, pred_taken, mispredict;
   logic [31:0]     branch_count, mispredict_count;
   logic            pred_valid_s, pred_taken_s, mispredict_s;
   logic [3:0]      branch_count_s, mispredict_count_s;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   bht #(.ENTRIES(64), .INIT_STATE(WNT), .CNT_W(32)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_lookup_valid(lookup_valid), .i_lookup_pc(lookup_pc), .i_flush(flush),
      .o_pred_valid(pred_valid), .o_pred_taken(pred_taken),
      .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_take(upd_take), .i_upd_pred(upd_pred),
      .o_mispredict(mispredict), .o_branch_count(branch_count), .o_mispredict_count(mispredict_count)
   );

   bht #(.ENTRIES(64), .INIT_STATE(WNT), .CNT_W(4)) dut_small (
      .i_clk(clk), .i_rst(rst),
      .i_lookup_valid(lookup_valid), .i_lookup_pc(lookup_pc), .i_flush(flush),
      .o_pred_valid(pred_valid_s), .o_pred_taken(pred_taken_s),
      .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_take(upd_take), .i_upd_pred(upd_pred),
      .o_mispredict(mispredict_s), .o_branch_count(branch_count_s), .o_mispredict_count(mispredict_count_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      lookup_valid = 1'b0;
      lookup_pc    = '0;
      flush        = 1'b0;
      upd_valid    = 1'b0;
      upd_pc       = '0;
      upd_take     = 1'b0;
      upd_pred     = 1'b0;
   endtask

   task automatic look(input logic [XLEN-1:0] pc);
      lookup_valid = 1'b1;
      lookup_pc    = pc;
   endtask

   task automatic upd(input logic [XLEN-1:0] pc, input logic take, input logic pred);
      upd_valid = 1'b1;
      upd_pc    = pc;
      upd_take  = take;
      upd_pred  = pred;
   endtask

   logic [9:0] takes    = 10'b1011001110;
   logic [9:0] preds    = 10'b1001101100;
   logic [9:0] exp_mis  = 10'b0010100010;

   initial begin
      idle();
      #2;
      check("reset_pred_valid", 32'(pred_valid), 32'd0);
      check("reset_pred_taken", 32'(pred_taken), 32'd0);
      check("reset_branch_count", branch_count, 32'd0);
      check("reset_mispredict_count", mispredict_count, 32'd0);
      #20;
      tick();
      rst = 1'b0;

      // Reset state: three back-to-back lookups all read WNT.
      look(32'h0);  tick();
      check("init_pc0_valid", 32'(pred_valid), 32'd1);
      check("init_pc0_taken", 32'(pred_taken), 32'd0);
      look(32'h4);  tick();
      check("init_pc4_valid", 32'(pred_valid), 32'd1);
      check("init_pc4_taken", 32'(pred_taken), 32'd0);
      look(32'hFC); tick();
      check("init_pcfc_valid", 32'(pred_valid), 32'd1);
      check("init_pcfc_taken", 32'(pred_taken), 32'd0);
      idle(); tick();
      check("idle_pred_valid", 32'(pred_valid), 32'd0);
      check("idle_pred_taken_hold", 32'(pred_taken), 32'd0);
      check("init_branch_count", branch_count, 32'd0);
      check("init_mispredict_count", mispredict_count, 32'd0);

      // Saturation up then down at pc 0x40.
      for (int i = 0; i < 3; i++) begin
         idle(); upd(32'h40, 1'b1, 1'b0); tick();
      end
      idle(); look(32'h40); tick();
      check("sat_st_taken", 32'(pred_taken), 32'd1);
      idle(); upd(32'h40, 1'b0, 1'b1); tick();
      idle(); look(32'h40); tick();
      check("sat_wt_taken", 32'(pred_taken), 32'd1);
      for (int i = 0; i < 3; i++) begin
         idle(); upd(32'h40, 1'b0, 1'b1); tick();
      end
      idle(); look(32'h40); tick();
      check("sat_snt_taken", 32'(pred_taken), 32'd0);
      idle(); upd(32'h40, 1'b1, 1'b0); tick();
      idle(); look(32'h40); tick();
      check("sat_no_underflow", 32'(pred_taken), 32'd0);

      // Write-first bypass on same index.
      idle(); look(32'h80); upd(32'h80, 1'b1, 1'b0); tick();
      check("bypass_valid", 32'(pred_valid), 32'd1);
      check("bypass_taken", 32'(pred_taken), 32'd1);

      // Flush kills the lookup but the concurrent update still trains.
      idle(); look(32'h10); flush = 1'b1; upd(32'h10, 1'b1, 1'b0); tick();
      check("flush_valid", 32'(pred_valid), 32'd0);
      check("flush_taken_hold", 32'(pred_taken), 32'd1);
      idle(); look(32'h10); tick();
      check("flush_update_committed", 32'(pred_taken), 32'd1);

      // Aliasing: 0x100 and 0x000 share index 0.
      for (int i = 0; i < 2; i++) begin
         idle(); upd(32'h100, 1'b1, 1'b0); tick();
      end
      idle(); look(32'h0); tick();
      check("alias_taken", 32'(pred_taken), 32'd1);

      // Counters from a clean reset.
      idle(); #2; rst = 1'b1; #1;
      check("pulse_branch_count", branch_count, 32'd0);
      tick(); rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         idle(); upd(32'h200 + 32'(4 * i), takes[i], preds[i]);
         #1;
         check($sformatf("mispredict_flag_%0d", i), 32'(mispredict), 32'(exp_mis[i]));
         tick();
      end
      idle(); upd_take = 1'b1; upd_pred = 1'b0; #1;
      check("mispredict_flag_invalid", 32'(mispredict), 32'd0);
      idle();
      check("cnt_branch_10", branch_count, 32'd10);
      check("cnt_mispredict_3", mispredict_count, 32'd3);
      check("cnt_small_branch_10", 32'(branch_count_s), 32'd10);
      for (int i = 0; i < 6; i++) begin
         idle(); upd(32'h300, 1'b1, 1'b1); tick();
      end
      idle();
      check("cnt_branch_16", branch_count, 32'd16);
      check("cnt_mispredict_still_3", mispredict_count, 32'd3);
      check("cnt_small_wrap", 32'(branch_count_s), 32'd0);

      // Async reset mid-stream: entry 1 driven to SNT, entry 2 to ST.
      for (int i = 0; i < 8; i++) begin
         idle(); look(32'h8);
         if (i % 2 == 0) upd(32'h4, 1'b0, 1'b1);
         else            upd(32'h8, 1'b1, 1'b0);
         tick();
      end
      check("pre_reset_taken", 32'(pred_taken), 32'd1);
      check("pre_reset_branch_count", branch_count, 32'd24);
      #2; rst = 1'b1; #1;
      check("async_pred_valid", 32'(pred_valid), 32'd0);
      check("async_pred_taken", 32'(pred_taken), 32'd0);
      check("async_branch_count", branch_count, 32'd0);
      check("async_mispredict_count", mispredict_count, 32'd0);
      idle(); tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 64; i++) begin
         idle(); look(32'(4 * i)); tick();
         check($sformatf("post_reset_lookup_%0d", i), {31'd0, pred_valid, pred_taken}, 32'd2);
      end
      for (int i = 0; i < 64; i++) begin
         idle(); look(32'(4 * i)); upd(32'(4 * i), 1'b1, 1'b1); tick();
         check($sformatf("post_reset_wnt_%0d", i), 32'(pred_taken), 32'd1);
      end
      idle(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
